i2c_slave_fsm: RTL and testbench
================================

Name: i2c_slave_fsm

Overview:
- I2C target (slave) FSM; the responder to the team's I2C master FSM on the same two-wire bus.
- Detects START/STOP and matches a fixed 7-bit address.
- Write transfers: receives up to NUM_BYTES data bytes and ACKs each.
- Read transfers: shifts out up to NUM_BYTES bytes from parallel inputs and monitors the master's ACK/NACK.
- Bus pins are sampled through synchronizers on the system clock; SDA is driven open-drain via an output-enable.

Parameters:
- ADDR_LEN, 7, address width in bits (only 7 is supported).
- DATA_LEN, 8, data byte width.
- SLAVE_ADDR, 7'h50, address this target responds to.
- NUM_BYTES, 2, maximum bytes accepted or supplied per transfer.

Ports:
- clk  input  1  system clock; all logic is on its rising edge.
- rst_n  input  1  asynchronous active-low reset.
- scl  input  1  raw bus SCL (asynchronous).
- sda_i  input  1  raw bus SDA (asynchronous).
- sda_oe  output  1  1 = pull SDA low; 0 = release SDA.
- tx_data_0  input  DATA_LEN  first byte returned on a read.
- tx_data_1  input  DATA_LEN  second byte returned on a read.
- rx_data  output  DATA_LEN  last byte received on a write.
- rx_index  output  1  index (0/1) of the byte in rx_data.
- rx_valid  output  1  one-clk pulse when rx_data is updated.
- addr_match  output  1  high from the address ACK until STOP or repeated START.
- rw  output  1  R/W bit latched from the address byte.
- state_slave  output  4  current state encoding.
- busy  output  1  high whenever state is not IDLE.

Behaviour:
- Reset (rst_n low, asynchronous):
  - Outputs: sda_oe=0, rx_data=0, rx_index=0, rx_valid=0, addr_match=0, rw=0, busy=0.
  - Internal: state=IDLE, synchronizers=1, bit counter=0, byte counter=0.
  - Reset mid-transfer releases SDA immediately.
- Synchronization: scl and sda_i each pass through a 2-FF synchronizer plus one history FF. Edges are detected on the synchronized values.
  - scl_rise / scl_fall: transitions of synchronized SCL.
  - START: synchronized SDA falls while synchronized SCL is high.
  - STOP: synchronized SDA rises while synchronized SCL is high.
- Bus timing requirement: each SCL half-period must be at least 4 clk cycles.
- Sampling and drive rules:
  - SDA is sampled on scl_rise.
  - sda_oe changes only on the clk following scl_fall, i.e. 3 clk after a raw SCL fall.
  - Exception: STOP and reset release SDA immediately.
- Bit order: MSB first. bit_cnt counts 0..7.
- State encodings:
  - IDLE=0
  - ADDR=1 (8 bits: address[6:0], then R/W)
  - ADDR_ACK=2
  - RX_BYTE=3
  - RX_ACK=4
  - TX_BYTE=5
  - TX_ACK_CHK=6
  - WAIT_STOP=7
- Transitions:
  - IDLE: START -> ADDR; clear bit_cnt and byte_cnt.
  - ADDR: after the 8th scl_rise, compare address[6:0] with SLAVE_ADDR.
    - Match: latch rw -> ADDR_ACK.
    - Mismatch: -> WAIT_STOP; sda_oe stays 0.
  - ADDR_ACK:
    - On scl_fall: sda_oe=1, addr_match=1.
    - On the following scl_fall: if rw=0, sda_oe=0 -> RX_BYTE; if rw=1, load shift register from tx_data_0 -> TX_BYTE.
  - RX_BYTE: shift on each scl_rise; after the 8th -> RX_ACK.
    - If byte_cnt<NUM_BYTES: rx_data=shifted byte, rx_index=byte_cnt[0], rx_valid pulses for 1 clk, byte_cnt increments.
    - If byte_cnt>=NUM_BYTES: the byte is discarded and NACKed.
  - RX_ACK:
    - On scl_fall: sda_oe=1 if the byte was accepted, else 0.
    - On the next scl_fall: release SDA; -> RX_BYTE if accepted, else WAIT_STOP.
  - TX_BYTE: on each scl_fall, sda_oe = ~shift_msb; shift left.
    - After the 8th bit's scl_fall, release SDA -> TX_ACK_CHK.
  - TX_ACK_CHK: sample SDA on scl_rise.
    - 0 (ACK): byte_cnt increments. Next byte = tx_data_1 if byte_cnt==1, else 8'hFF. -> TX_BYTE; its first bit is driven on the next scl_fall.
    - 1 (NACK): -> WAIT_STOP.
  - WAIT_STOP: hold sda_oe=0.
- Global overrides (any state, highest priority):
  - STOP: -> IDLE, sda_oe=0, addr_match=0.
  - START (repeated): -> ADDR, bit_cnt=0, byte_cnt=0, addr_match=0, sda_oe=0.
- Simultaneous events: STOP/START outrank SCL-edge actions on the same clk.
- Tracking rules: bit_cnt wraps 7->0 at byte boundaries only. byte_cnt saturates at NUM_BYTES.

Test Plan:
1. Write 0xA0 (addr 0x50, W), bytes 0x3C, 0xC3, STOP:
   - ACK on address and both bytes.
   - rx_valid pulses twice: (rx_index 0, rx_data 0x3C), then (rx_index 1, rx_data 0xC3).
   - busy falls within 3 clk of STOP.
2. Read 0xA1 with tx_data_0=0x5A, tx_data_1=0x96; master ACKs byte 0, NACKs byte 1:
   - SDA carries 0x5A then 0x96.
   - -> WAIT_STOP, then IDLE on STOP; sda_oe=0 throughout the master-ACK bits.
3. Address 0x51 (W):
   - sda_oe never asserts; state=WAIT_STOP until STOP; rx_valid never pulses.
4. Write 3 bytes 0x11, 0x22, 0x33:
   - First two are ACKed with rx_valid.
   - Third is NACKed (SDA released in its ACK slot), with no third rx_valid.
5. Repeated START after a write of 0x11, then 0xA1 read:
   - state returns to ADDR, byte_cnt=0, rw=1.
   - First read byte = tx_data_0.
6. rst_n asserted low mid-read while sda_oe=1:
   - sda_oe=0 and state=IDLE in the same cycle with no clk edge.
   - After release, the next START addresses normally.

Source files
------------

// File: rtl/i2c_slave_fsm.sv
// I2C target FSM: synchronised SCL/SDA sampling, START/STOP detection, fixed 7-bit address,
// write reception with per-byte ACK and read transmission with master ACK/NACK monitoring.
module i2c_slave_fsm #(
    parameter int                  ADDR_LEN   = 7,
    parameter int                  DATA_LEN   = 8,
    parameter logic [ADDR_LEN-1:0] SLAVE_ADDR = 7'h50,
    parameter int                  NUM_BYTES  = 2
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                scl,
    input  logic                sda_i,
    output logic                sda_oe,
    input  logic [DATA_LEN-1:0] tx_data_0,
    input  logic [DATA_LEN-1:0] tx_data_1,
    output logic [DATA_LEN-1:0] rx_data,
    output logic                rx_index,
    output logic                rx_valid,
    output logic                addr_match,
    output logic                rw,
    output logic [3:0]          state_slave,
    output logic                busy
);

    localparam int BIT_W  = $clog2(DATA_LEN);
    localparam int BYTE_W = $clog2(NUM_BYTES + 1);
    localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(DATA_LEN - 1);
    localparam logic [BYTE_W-1:0] BYTE_MAX  = BYTE_W'(NUM_BYTES);

    typedef enum logic [3:0] {
        IDLE       = 4'd0,
        ADDR       = 4'd1,
        ADDR_ACK   = 4'd2,
        RX_BYTE    = 4'd3,
        RX_ACK     = 4'd4,
        TX_BYTE    = 4'd5,
        TX_ACK_CHK = 4'd6,
        WAIT_STOP  = 4'd7
    } state_t;

    state_t              state, state_n;
    logic                scl_s1, scl_s2, scl_d;
    logic                sda_s1, sda_s2, sda_d;
    logic [BIT_W-1:0]    bit_cnt, bit_cnt_n;
    logic [BYTE_W-1:0]   byte_cnt, byte_cnt_n, byte_cnt_inc;
    logic [DATA_LEN-1:0] shift, shift_n, rx_byte;
    logic                phase, phase_n;
    logic                accepted, accepted_n;
    logic                sda_oe_n, rx_index_n, rx_valid_n, addr_match_n, rw_n;
    logic [DATA_LEN-1:0] rx_data_n;
    logic                scl_rise, scl_fall, start_det, stop_det;

    // Synchronizers idle high so a released bus never looks like an edge after reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            scl_s1 <= 1'b1;
            scl_s2 <= 1'b1;
            scl_d  <= 1'b1;
            sda_s1 <= 1'b1;
            sda_s2 <= 1'b1;
            sda_d  <= 1'b1;
        end else begin
            scl_s1 <= scl;
            scl_s2 <= scl_s1;
            scl_d  <= scl_s2;
            sda_s1 <= sda_i;
            sda_s2 <= sda_s1;
            sda_d  <= sda_s2;
        end
    end

    assign scl_rise  = scl_s2 & ~scl_d;
    assign scl_fall  = ~scl_s2 & scl_d;
    assign start_det = scl_s2 & sda_d & ~sda_s2;
    assign stop_det  = scl_s2 & ~sda_d & sda_s2;

    assign rx_byte      = {shift[DATA_LEN-2:0], sda_s2};
    assign byte_cnt_inc = (byte_cnt < BYTE_MAX) ? byte_cnt + 1'b1 : byte_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            bit_cnt    <= '0;
            byte_cnt   <= '0;
            shift      <= '0;
            phase      <= 1'b0;
            accepted   <= 1'b0;
            sda_oe     <= 1'b0;
            rx_data    <= '0;
            rx_index   <= 1'b0;
            rx_valid   <= 1'b0;
            addr_match <= 1'b0;
            rw         <= 1'b0;
        end else begin
            state      <= state_n;
            bit_cnt    <= bit_cnt_n;
            byte_cnt   <= byte_cnt_n;
            shift      <= shift_n;
            phase      <= phase_n;
            accepted   <= accepted_n;
            sda_oe     <= sda_oe_n;
            rx_data    <= rx_data_n;
            rx_index   <= rx_index_n;
            rx_valid   <= rx_valid_n;
            addr_match <= addr_match_n;
            rw         <= rw_n;
        end
    end

    // phase marks the second half of an ACK slot, or in TX_BYTE that all data bits are out.
    always_comb begin
        state_n      = state;
        bit_cnt_n    = bit_cnt;
        byte_cnt_n   = byte_cnt;
        shift_n      = shift;
        phase_n      = phase;
        accepted_n   = accepted;
        sda_oe_n     = sda_oe;
        rx_data_n    = rx_data;
        rx_index_n   = rx_index;
        rx_valid_n   = 1'b0;
        addr_match_n = addr_match;
        rw_n         = rw;

        if (stop_det) begin
            state_n      = IDLE;
            sda_oe_n     = 1'b0;
            addr_match_n = 1'b0;
        end else if (start_det) begin
            state_n      = ADDR;
            bit_cnt_n    = '0;
            byte_cnt_n   = '0;
            phase_n      = 1'b0;
            addr_match_n = 1'b0;
            sda_oe_n     = 1'b0;
        end else begin
            case (state)
                ADDR: if (scl_rise) begin
                    shift_n = rx_byte;
                    if (bit_cnt == BIT_LAST) begin
                        bit_cnt_n = '0;
                        if (shift[ADDR_LEN-1:0] == SLAVE_ADDR) begin
                            rw_n    = sda_s2;
                            phase_n = 1'b0;
                            state_n = ADDR_ACK;
                        end else begin
                            state_n = WAIT_STOP;
                        end
                    end else begin
                        bit_cnt_n = bit_cnt + 1'b1;
                    end
                end
                ADDR_ACK: if (scl_fall) begin
                    if (!phase) begin
                        sda_oe_n     = 1'b1;
                        addr_match_n = 1'b1;
                        phase_n      = 1'b1;
                    end else begin
                        phase_n = 1'b0;
                        if (!rw) begin
                            sda_oe_n  = 1'b0;
                            bit_cnt_n = '0;
                            state_n   = RX_BYTE;
                        end else begin
                            // The first read bit must already be on the bus for the next SCL high.
                            sda_oe_n  = ~tx_data_0[DATA_LEN-1];
                            shift_n   = {tx_data_0[DATA_LEN-2:0], 1'b0};
                            bit_cnt_n = BIT_W'(1);
                            state_n   = TX_BYTE;
                        end
                    end
                end
                RX_BYTE: if (scl_rise) begin
                    shift_n = rx_byte;
                    if (bit_cnt == BIT_LAST) begin
                        bit_cnt_n = '0;
                        phase_n   = 1'b0;
                        state_n   = RX_ACK;
                        if (byte_cnt < BYTE_MAX) begin
                            rx_data_n  = rx_byte;
                            rx_index_n = byte_cnt[0];
                            rx_valid_n = 1'b1;
                            byte_cnt_n = byte_cnt_inc;
                            accepted_n = 1'b1;
                        end else begin
                            accepted_n = 1'b0;
                        end
                    end else begin
                        bit_cnt_n = bit_cnt + 1'b1;
                    end
                end
                RX_ACK: if (scl_fall) begin
                    if (!phase) begin
                        sda_oe_n = accepted;
                        phase_n  = 1'b1;
                    end else begin
                        sda_oe_n = 1'b0;
                        phase_n  = 1'b0;
                        state_n  = accepted ? RX_BYTE : WAIT_STOP;
                    end
                end
                TX_BYTE: if (scl_fall) begin
                    if (phase) begin
                        sda_oe_n = 1'b0;
                        phase_n  = 1'b0;
                        state_n  = TX_ACK_CHK;
                    end else begin
                        sda_oe_n = ~shift[DATA_LEN-1];
                        shift_n  = shift << 1;
                        if (bit_cnt == BIT_LAST) begin
                            bit_cnt_n = '0;
                            phase_n   = 1'b1;
                        end else begin
                            bit_cnt_n = bit_cnt + 1'b1;
                        end
                    end
                end
                TX_ACK_CHK: if (scl_rise) begin
                    if (!sda_s2) begin
                        byte_cnt_n = byte_cnt_inc;
                        shift_n    = (byte_cnt_inc == BYTE_W'(1)) ? tx_data_1 : '1;
                        bit_cnt_n  = '0;
                        phase_n    = 1'b0;
                        state_n    = TX_BYTE;
                    end else begin
                        state_n = WAIT_STOP;
                    end
                end
                WAIT_STOP: sda_oe_n = 1'b0;
                default: ;
            endcase
        end
    end

    assign state_slave = state;
    assign busy        = (state != IDLE);

endmodule

// File: tb/tb_i2c_slave_fsm.sv
// Directed bench for i2c_slave_fsm: a table of bus transactions driven by a bit-level
// master model, plus hand-written repeated-START and mid-transfer reset sequences.
module tb_i2c_slave_fsm;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       scl_m, sda_m, sda_bus;
    logic [7:0] tx_data_0, tx_data_1, rx_data;
    logic       sda_oe, rx_index, rx_valid, addr_match, rw, busy;
    logic [3:0] state_slave;

    int tests = 0;
    int fails = 0;

    logic [8:0] rx_log [$];
    int         oe_cnt = 0;

    typedef struct packed {
        logic [7:0]      addr_byte;
        int              nbytes;
        logic [2:0][7:0] wdata;
        logic [7:0]      tx0;
        logic [7:0]      tx1;
        logic [2:0]      master_nack;
        logic            exp_addr_ack;
        logic [2:0]      exp_ack;
        logic [2:0][7:0] exp_rd;
        int              exp_rx_cnt;
        logic [3:0]      exp_state;
    } vec_t;

    vec_t vecs [5];
    vec_t rst_vec;

    assign sda_bus = sda_m & ~sda_oe;

    i2c_slave_fsm dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .scl        (scl_m),
        .sda_i      (sda_bus),
        .sda_oe     (sda_oe),
        .tx_data_0  (tx_data_0),
        .tx_data_1  (tx_data_1),
        .rx_data    (rx_data),
        .rx_index   (rx_index),
        .rx_valid   (rx_valid),
        .addr_match (addr_match),
        .rw         (rw),
        .state_slave(state_slave),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (rx_valid) rx_log.push_back({rx_index, rx_data});
        if (sda_oe) oe_cnt = oe_cnt + 1;
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        tests++;
        if (actual !== expected) begin
            fails++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
        end
    endtask

    task automatic busStart();
        sda_m = 1'b0;
        tick(8);
        scl_m = 1'b0;
        tick(2);
    endtask

    task automatic bitCycle(input logic b, output logic bus, output logic oe);
        sda_m = b;
        tick(6);
        scl_m = 1'b1;
        tick(4);
        bus = sda_bus;
        oe  = sda_oe;
        tick(4);
        scl_m = 1'b0;
        tick(2);
    endtask

    task automatic busStop(input string tag);
        logic b;
        sda_m = 1'b0;
        tick(6);
        scl_m = 1'b1;
        tick(6);
        sda_m = 1'b1;
        tick(3);
        b = busy;
        checkOutput({tag, " busy_after_stop"}, b, 1'b0);
        checkOutput({tag, " state_after_stop"}, state_slave, 4'd0);
        b = addr_match;
        checkOutput({tag, " addr_match_after_stop"}, b, 1'b0);
        tick(8);
    endtask

    task automatic sendByte(input logic [7:0] d);
        logic bus, oe;
        for (int b = 7; b >= 0; b--) bitCycle(d[b], bus, oe);
    endtask

    task automatic applyStimulus(input vec_t v, input string tag);
        logic       bus, oe, ack, bit_v;
        logic [7:0] rd;
        int         rx_base, oe_base, cnt;
        tx_data_0 = v.tx0;
        tx_data_1 = v.tx1;
        rx_base   = rx_log.size();
        oe_base   = oe_cnt;
        busStart();
        sendByte(v.addr_byte);
        bitCycle(1'b1, bus, oe);
        ack = ~bus;
        checkOutput({tag, " addr_ack"}, ack, v.exp_addr_ack);
        bit_v = addr_match;
        checkOutput({tag, " addr_match"}, bit_v, v.exp_addr_ack);
        if (v.exp_addr_ack) begin
            bit_v = rw;
            checkOutput({tag, " rw"}, bit_v, v.addr_byte[0]);
        end
        for (int i = 0; i < v.nbytes; i++) begin
            if (v.addr_byte[0] && v.exp_addr_ack) begin
                for (int b = 7; b >= 0; b--) begin
                    bitCycle(1'b1, bus, oe);
                    rd[b] = bus;
                end
                bitCycle(v.master_nack[i], bus, oe);
                checkOutput($sformatf("%s read_byte%0d", tag, i), rd, v.exp_rd[i]);
                checkOutput($sformatf("%s oe_in_master_ack%0d", tag, i), oe, 1'b0);
            end else begin
                sendByte(v.wdata[i]);
                bitCycle(1'b1, bus, oe);
                ack = ~bus;
                checkOutput($sformatf("%s data_ack%0d", tag, i), ack, v.exp_ack[i]);
            end
        end
        tick(2);
        checkOutput({tag, " state_before_stop"}, state_slave, v.exp_state);
        cnt = rx_log.size() - rx_base;
        checkOutput({tag, " rx_valid_count"}, cnt, v.exp_rx_cnt);
        for (int i = 0; i < v.exp_rx_cnt && i < cnt; i++)
            checkOutput($sformatf("%s rx_entry%0d", tag, i), rx_log[rx_base + i],
                        {i[0], v.wdata[i]});
        if (!v.exp_addr_ack)
            checkOutput({tag, " oe_never_set"}, oe_cnt - oe_base, 0);
        busStop(tag);
    endtask

    initial begin
        logic       bus, oe, ack, bit_v;
        logic [7:0] rd;
        int         rx_base;

        vecs[0] = '{addr_byte: 8'hA0, nbytes: 2, wdata: {8'h00, 8'hC3, 8'h3C},
                    tx0: 8'h00, tx1: 8'h00, master_nack: 3'b000, exp_addr_ack: 1'b1,
                    exp_ack: 3'b011, exp_rd: '0, exp_rx_cnt: 2, exp_state: 4'd3};
        vecs[1] = '{addr_byte: 8'hA1, nbytes: 2, wdata: '0,
                    tx0: 8'h5A, tx1: 8'h96, master_nack: 3'b010, exp_addr_ack: 1'b1,
                    exp_ack: 3'b000, exp_rd: {8'h00, 8'h96, 8'h5A}, exp_rx_cnt: 0,
                    exp_state: 4'd7};
        vecs[2] = '{addr_byte: 8'hA2, nbytes: 1, wdata: {8'h00, 8'h00, 8'h77},
                    tx0: 8'h00, tx1: 8'h00, master_nack: 3'b000, exp_addr_ack: 1'b0,
                    exp_ack: 3'b000, exp_rd: '0, exp_rx_cnt: 0, exp_state: 4'd7};
        vecs[3] = '{addr_byte: 8'hA0, nbytes: 3, wdata: {8'h33, 8'h22, 8'h11},
                    tx0: 8'h00, tx1: 8'h00, master_nack: 3'b000, exp_addr_ack: 1'b1,
                    exp_ack: 3'b011, exp_rd: '0, exp_rx_cnt: 2, exp_state: 4'd7};
        vecs[4] = '{addr_byte: 8'hA1, nbytes: 3, wdata: '0,
                    tx0: 8'h01, tx1: 8'h80, master_nack: 3'b100, exp_addr_ack: 1'b1,
                    exp_ack: 3'b000, exp_rd: {8'hFF, 8'h80, 8'h01}, exp_rx_cnt: 0,
                    exp_state: 4'd7};
        rst_vec = '{addr_byte: 8'hA0, nbytes: 1, wdata: {8'h00, 8'h00, 8'h5E},
                    tx0: 8'h00, tx1: 8'h00, master_nack: 3'b000, exp_addr_ack: 1'b1,
                    exp_ack: 3'b001, exp_rd: '0, exp_rx_cnt: 1, exp_state: 4'd3};

        rst_n = 1'b0;
        scl_m = 1'b1;
        sda_m = 1'b1;
        tx_data_0 = 8'h00;
        tx_data_1 = 8'h00;
        tick(3);
        bit_v = sda_oe;     checkOutput("reset sda_oe", bit_v, 1'b0);
        checkOutput("reset rx_data", rx_data, 8'h00);
        bit_v = rx_index;   checkOutput("reset rx_index", bit_v, 1'b0);
        bit_v = rx_valid;   checkOutput("reset rx_valid", bit_v, 1'b0);
        bit_v = addr_match; checkOutput("reset addr_match", bit_v, 1'b0);
        bit_v = rw;         checkOutput("reset rw", bit_v, 1'b0);
        bit_v = busy;       checkOutput("reset busy", bit_v, 1'b0);
        checkOutput("reset state", state_slave, 4'd0);
        rst_n = 1'b1;
        tick(10);

        for (int v = 0; v < 5; v++)
            applyStimulus(vecs[v], $sformatf("vec%0d", v));

        // Repeated START after one written byte, then a read from the top of the buffer.
        tx_data_0 = 8'hC5;
        tx_data_1 = 8'h3A;
        rx_base = rx_log.size();
        busStart();
        sendByte(8'hA0);
        bitCycle(1'b1, bus, oe);
        ack = ~bus;
        checkOutput("rs addr_ack_w", ack, 1'b1);
        sendByte(8'h11);
        bitCycle(1'b1, bus, oe);
        ack = ~bus;
        checkOutput("rs data_ack", ack, 1'b1);
        sda_m = 1'b1;
        tick(6);
        scl_m = 1'b1;
        tick(6);
        sda_m = 1'b0;
        tick(6);
        checkOutput("rs state_addr", state_slave, 4'd1);
        bit_v = addr_match;
        checkOutput("rs addr_match_cleared", bit_v, 1'b0);
        scl_m = 1'b0;
        tick(2);
        sendByte(8'hA1);
        bitCycle(1'b1, bus, oe);
        ack = ~bus;
        checkOutput("rs addr_ack_r", ack, 1'b1);
        bit_v = rw;
        checkOutput("rs rw", bit_v, 1'b1);
        for (int b = 7; b >= 0; b--) begin
            bitCycle(1'b1, bus, oe);
            rd[b] = bus;
        end
        bitCycle(1'b1, bus, oe);
        checkOutput("rs first_read_byte", rd, 8'hC5);
        tick(2);
        checkOutput("rs state_wait_stop", state_slave, 4'd7);
        checkOutput("rs rx_count", rx_log.size() - rx_base, 1);
        if (rx_log.size() > rx_base)
            checkOutput("rs rx_entry", rx_log[rx_base], {1'b0, 8'h11});
        busStop("rs");

        // Asynchronous reset while the target is pulling SDA low during a read.
        tx_data_0 = 8'h00;
        tx_data_1 = 8'hFF;
        busStart();
        sendByte(8'hA1);
        bitCycle(1'b1, bus, oe);
        bitCycle(1'b1, bus, oe);
        checkOutput("rst pre_oe", oe, 1'b1);
        #3;
        rst_n = 1'b0;
        #1;
        bit_v = sda_oe;
        checkOutput("rst async_sda_oe", bit_v, 1'b0);
        checkOutput("rst async_state", state_slave, 4'd0);
        bit_v = busy;
        checkOutput("rst async_busy", bit_v, 1'b0);
        tick(2);
        rst_n = 1'b1;
        sda_m = 1'b1;
        scl_m = 1'b1;
        tick(10);
        applyStimulus(rst_vec, "after_rst");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
